// File: rtl/upower_mc_ctrl.sv
// Multi-cycle sequencer for the uPower core: FETCH/DECODE/EXEC/MEM/WB control strobes.
// Optional single-step gating of instruction accept when UPOWER_CTRL_STEP_EN is defined.
module upower_mc_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef UPOWER_CTRL_STEP_EN
    input  logic             step,
`endif
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic [31:0]      ir,
    output logic             alu_en,
    input  logic             alu_branch,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             illegal,
    output logic             bus_err,
    output logic             busy,
    output logic [CNT_W-1:0] retired
);

    localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb} state_e;
    typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBrc, ClsBru, ClsIll} cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, dec_cls;
    logic [31:0]       ir_q;
    logic              br_q;
    logic              err_q;
    logic [TW-1:0]     tcnt_q;
    logic [CNT_W-1:0]  retired_q;
    logic              fetch_ok;
    logic              accept;

`ifdef UPOWER_CTRL_STEP_EN
    logic step_q;
    logic step_pend_q;

    // A step edge seen in the accept cycle belongs to the next instruction, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            step_q <= step;
            if (step && !step_q) begin
                step_pend_q <= 1'b1;
            end else if (accept) begin
                step_pend_q <= 1'b0;
            end
        end
    end

    assign fetch_ok = (state_q == StFetch) && step_pend_q;
`else
    assign fetch_ok = (state_q == StFetch);
`endif

    assign accept = fetch_ok && instr_valid;

    always_comb begin
        dec_cls = ClsIll;
        case (ir_q[31:26])
            6'd31, 6'd14, 6'd15, 6'd28, 6'd24, 6'd26: dec_cls = ClsAlu;
            6'd32, 6'd34, 6'd40, 6'd42, 6'd58:        dec_cls = ClsLoad;
            6'd36, 6'd37, 6'd38, 6'd44, 6'd62:        dec_cls = ClsStore;
            6'd19:                                    dec_cls = ClsBrc;
            6'd18:                                    dec_cls = ClsBru;
            default:                                  dec_cls = ClsIll;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   state_d = StFetch;
            StFetch:  if (accept) state_d = StDecode;
            StDecode: state_d = (dec_cls == ClsIll) ? StWb : StExec;
            StExec:   state_d = (cls_q == ClsLoad || cls_q == ClsStore) ? StMem : StWb;
            StMem:    if (mem_ack || tcnt_q == TO_LAST) state_d = StWb;
            StWb:     state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q      <= '0;
            cls_q     <= ClsAlu;
            br_q      <= 1'b0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
            retired_q <= '0;
        end else begin
            if (accept) begin
                ir_q <= instr;
            end
            if (state_q == StDecode) begin
                cls_q <= dec_cls;
                br_q  <= 1'b0;
                err_q <= 1'b0;
            end
            if (state_q == StExec) begin
                br_q   <= alu_branch;
                tcnt_q <= '0;
            end
            // Ack in the final MEM cycle wins over the timeout.
            if (state_q == StMem && !mem_ack) begin
                if (tcnt_q == TO_LAST) begin
                    err_q <= 1'b1;
                end else begin
                    tcnt_q <= tcnt_q + TW'(1);
                end
            end
            if (state_q == StWb && cls_q != ClsIll && !err_q) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Outputs decode from registered state and flags only
    always_comb begin
        instr_ready = fetch_ok;
        busy        = (state_q != StIdle) && (state_q != StFetch);
        alu_en      = (state_q == StExec);
        mem_req     = (state_q == StMem);
        mem_we      = (state_q == StMem) && (cls_q == ClsStore);
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 2'b00;
        illegal     = 1'b0;
        bus_err     = 1'b0;
        if (state_q == StWb) begin
            pc_we   = 1'b1;
            reg_we  = (cls_q == ClsAlu || cls_q == ClsLoad) && !err_q;
            wb_sel  = (cls_q == ClsLoad);
            illegal = (cls_q == ClsIll);
            bus_err = err_q;
            if (cls_q == ClsBru) begin
                pc_sel = 2'b10;
            end else if (cls_q == ClsBrc && br_q) begin
                pc_sel = 2'b01;
            end
        end
    end

    assign ir      = ir_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_upower_mc_ctrl.sv
// Self-checking bench for upower_mc_ctrl: directed instructions with a WB-result scoreboard.
// Also exercises single-step accept when built with UPOWER_CTRL_STEP_EN.
module tb_upower_mc_ctrl;

    localparam int TO = 15;

    logic        clk;
    logic        rst_n;
`ifdef UPOWER_CTRL_STEP_EN
    logic        step;
`endif
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] ir;
    logic        alu_en;
    logic        alu_branch;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic        reg_we;
    logic        wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        illegal;
    logic        bus_err;
    logic        busy;
    logic [31:0] retired;

    upower_mc_ctrl #(
        .CNT_W      (32),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef UPOWER_CTRL_STEP_EN
        .step       (step),
`endif
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .ir         (ir),
        .alu_en     (alu_en),
        .alu_branch (alu_branch),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .reg_we     (reg_we),
        .wb_sel     (wb_sel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .busy       (busy),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        reg_we;
        logic        wb_sel;
        logic [1:0]  pc_sel;
        logic        illegal;
        logic        bus_err;
        logic        mem_we;
        int          lat;
        int          mem_cyc;
        int          alu_cyc;
        logic [31:0] retired;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_retired;
`ifdef UPOWER_CTRL_STEP_EN
    localparam logic RDY_AFTER_WB = 1'b0;
`else
    localparam logic RDY_AFTER_WB = 1'b1;
`endif

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 alu, 1 load, 2 store, 3 brc, 4 bru, 5 illegal
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'd31, 6'd14, 6'd15, 6'd28, 6'd24, 6'd26: return 0;
            6'd32, 6'd34, 6'd40, 6'd42, 6'd58:        return 1;
            6'd36, 6'd37, 6'd38, 6'd44, 6'd62:        return 2;
            6'd19:                                    return 3;
            6'd18:                                    return 4;
            default:                                  return 5;
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
`ifdef UPOWER_CTRL_STEP_EN
        step = 1'b1;
        tick();
        step = 1'b0;
`endif
        while (!instr_ready && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, instr_ready, 1);
    endtask

    // ack_at: MEM cycle (1-based) in which mem_ack is raised; 0 = never
    task automatic run_instr(input string tag, input logic [31:0] w, input logic br,
                             input int ack_at);
        exp_t e;
        int   c;
        int   k;
        int   cyc;
        int   alu_n;
        int   alu_at;
        int   mem_n;
        logic mem_we_seen;
        logic done;
        c = cls_of(w[31:26]);
        k = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
        e.bus_err = (c == 1 || c == 2) && !(ack_at >= 1 && ack_at <= TO);
        e.illegal = (c == 5);
        e.reg_we  = (c == 0 || c == 1) && !e.bus_err;
        e.wb_sel  = (c == 1);
        e.pc_sel  = (c == 4) ? 2'b10 : (c == 3 && br) ? 2'b01 : 2'b00;
        e.mem_we  = (c == 2);
        e.mem_cyc = (c == 1 || c == 2) ? k : 0;
        e.alu_cyc = (c == 5) ? 0 : 1;
        e.lat     = (c == 5) ? 2 : (c == 1 || c == 2) ? 3 + k : 3;
        if (!e.illegal && !e.bus_err) exp_retired = exp_retired + 1;
        e.retired = exp_retired;

        wait_ready(tag);
        instr       = w;
        instr_valid = 1'b1;
        alu_branch  = br;
        sb.push_back(e);
        tick();
        instr_valid = 1'b0;
        instr       = 32'hdead_beef;
        cyc         = 1;
        alu_n       = 0;
        alu_at      = -1;
        mem_n       = 0;
        mem_we_seen = 1'b0;
        done        = 1'b0;
        while (!done && cyc < 60) begin
            if (alu_en) begin
                alu_n++;
                alu_at = cyc;
            end
            if (mem_req) begin
                mem_n++;
                mem_we_seen = mem_we_seen | mem_we;
            end
            mem_ack = mem_req && (mem_n == ack_at);
            if (pc_we) begin
                done    = 1'b1;
                mem_ack = 1'b0;
                e = sb.pop_front();
                check({tag, "_reg_we"}, reg_we, e.reg_we);
                check({tag, "_wb_sel"}, wb_sel, e.wb_sel);
                check({tag, "_pc_sel"}, pc_sel, e.pc_sel);
                check({tag, "_illegal"}, illegal, e.illegal);
                check({tag, "_bus_err"}, bus_err, e.bus_err);
                check({tag, "_latency"}, cyc, e.lat);
                check({tag, "_alu_cycles"}, alu_n, e.alu_cyc);
                check({tag, "_mem_cycles"}, mem_n, e.mem_cyc);
                check({tag, "_mem_we"}, mem_we_seen, e.mem_we);
                check({tag, "_ir"}, ir, w);
                check({tag, "_busy"}, busy, 1);
                if (e.alu_cyc == 1) check({tag, "_alu_at"}, alu_at, 2);
            end else begin
                check({tag, "_no_wb_strobes"}, {illegal, bus_err, reg_we, pc_sel}, 0);
                tick();
                cyc++;
            end
        end
        check({tag, "_wb_seen"}, done, 1);
        tick();
        check({tag, "_retired"}, retired, e.retired);
        check({tag, "_ready_after_wb"}, instr_ready, RDY_AFTER_WB);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        n_cmp       = 0;
        n_fail      = 0;
        exp_retired = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        alu_branch  = 1'b0;
        mem_ack     = 1'b0;
`ifdef UPOWER_CTRL_STEP_EN
        step        = 1'b0;
`endif
        tick();
        tick();
        check("rst_outputs", {instr_ready, alu_en, mem_req, mem_we, reg_we, wb_sel, pc_we,
                              pc_sel, illegal, bus_err, busy}, 0);
        check("rst_ir", ir, 0);
        check("rst_retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_instr("add",       {6'd31, 5'd3, 5'd1, 5'd2, 1'b0, 9'd266, 1'b0}, 1'b0, 0);
        run_instr("bne_taken", {6'd19, 26'h0000_104}, 1'b1, 0);
        run_instr("bne_not",   {6'd19, 26'h0000_104}, 1'b0, 0);
        run_instr("bru",       {6'd18, 26'h0000_020}, 1'b1, 0);
        run_instr("ld_ack3",   {6'd58, 26'h012_3450}, 1'b0, 3);
        run_instr("st_to",     {6'd36, 26'h00a_bcd0}, 1'b0, 0);
        run_instr("st_ack15",  {6'd36, 26'h00a_bcd4}, 1'b0, TO);
        run_instr("illegal7",  {6'd7,  26'h155_5555}, 1'b1, 0);
        run_instr("addi",      {6'd14, 26'h004_0001}, 1'b0, 0);
        run_instr("lbz_ack1",  {6'd34, 26'h000_0008}, 1'b0, 1);

        // Abort during MEM via reset
        wait_ready("rst_mid");
        instr       = {6'd32, 26'h000_0010};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        tick();
        check("rst_mid_in_mem", mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {instr_ready, alu_en, mem_req, mem_we, reg_we, wb_sel, pc_we,
                                  pc_sel, illegal, bus_err, busy}, 0);
        check("rst_mid_ir", ir, 0);
        check("rst_mid_retired", retired, 0);
        exp_retired = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_rel_idle_ready", instr_ready, 0);
        tick();
        check("rst_rel_fetch_ready", instr_ready, RDY_AFTER_WB);
        check("rst_rel_busy", busy, 0);
        run_instr("post_rst_add", {6'd31, 5'd4, 5'd5, 5'd6, 1'b0, 9'd266, 1'b0}, 1'b0, 0);

`ifdef UPOWER_CTRL_STEP_EN
        begin
            int acc;
            acc = 0;
            tick();
            instr       = {6'd31, 5'd3, 5'd1, 5'd2, 1'b0, 9'd266, 1'b0};
            instr_valid = 1'b1;
            alu_branch  = 1'b0;
            for (int i = 0; i < 30; i++) begin
                step = (i == 2 || i == 12);
                if (instr_ready) acc++;
                tick();
            end
            instr_valid = 1'b0;
            step        = 1'b0;
            check("step_accepts", acc, 2);
            check("step_retired", retired, exp_retired + 2);
        end
`endif

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
